idwt53_recon: RTL and testbench

- Inverse of the streaming 1-D LeGall 5/3 DWT stage (TOP, L_out/H_out).
- Consumes one (L,H) coefficient pair per accepted beat and reconstructs one (even,odd) 8-bit sample pair.
- Sits downstream of the forward transform or coefficient storage; used for round-trip checking against the original input streams.
- Frames are delimited by in_last; symmetric boundary extension is applied at both frame ends.

---
 rtl/idwt_pkg.sv | 35 +++
 rtl/idwt53_recon_if.sv | 27 ++
 rtl/idwt53_lift.sv | 33 +++
 rtl/idwt53_recon.sv | 99 +++++++++
 tb/tb_idwt53_recon.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/idwt_pkg.sv
// Shared types and helpers for the inverse LeGall 5/3 reconstruction stage.
// Build option IDWT53_SAT_EN clamps outputs to 0..2^DW-1 instead of wrapping.
package idwt_pkg;

    localparam int DW = 8;
    localparam int IW = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    function automatic logic signed [IW-1:0] sext_h(logic [DW-1:0] h);
        return {{(IW-DW){h[DW-1]}}, h};
    endfunction

    function automatic logic signed [IW-1:0] zext_l(logic [DW-1:0] l);
        return {{(IW-DW){1'b0}}, l};
    endfunction

    function automatic logic [DW-1:0] to_out(logic signed [IW-1:0] v);
`ifdef IDWT53_SAT_EN
        if (v[IW-1])
            return '0;
        else if (v > IW'((1 << DW) - 1))
            return '1;
        else
            return v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

endpackage

// File: rtl/idwt53_recon_if.sv
// Coefficient-in / sample-out stream bundle for idwt53_recon.
// The slave side is the reconstruction block, the master side its environment.
interface idwt53_recon_if;
    import idwt_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [DW-1:0] L_in;
    logic [DW-1:0] H_in;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] x_even;
    logic [DW-1:0] x_odd;

    modport master (
        output in_valid, in_last, L_in, H_in, out_ready,
        input  in_ready, out_valid, out_last, x_even, x_odd
    );

    modport slave (
        input  in_valid, in_last, L_in, H_in, out_ready,
        output in_ready, out_valid, out_last, x_even, x_odd
    );

endinterface

// File: rtl/idwt53_lift.sv
// Combinational inverse lifting: undo the update step for e[n],
// then undo the predict step for o[n-1] using unsaturated e values.
module idwt53_lift
    import idwt_pkg::*;
(
    input  logic signed [IW-1:0] h_prev_i,
    input  logic signed [IW-1:0] h_cur_i,
    input  logic signed [IW-1:0] l_cur_i,
    input  logic signed [IW-1:0] e_prev_i,
    output logic signed [IW-1:0] e_cur_o,
    output logic signed [IW-1:0] o_prev_o
);

    localparam logic signed [IW:0] RND = (IW+1)'(2);

    // One guard bit: sums of two IW-bit values can exceed IW bits
    logic signed [IW:0]   h_sum;
    logic signed [IW:0]   e_sum;
    logic signed [IW-1:0] h_q4;
    logic signed [IW-1:0] e_h2;

    always_comb begin
        h_sum    = {h_prev_i[IW-1], h_prev_i}
                 + {h_cur_i[IW-1], h_cur_i} + RND;
        h_q4     = IW'(h_sum >>> 2);
        e_cur_o  = l_cur_i - h_q4;
        e_sum    = {e_prev_i[IW-1], e_prev_i}
                 + {e_cur_o[IW-1], e_cur_o};
        e_h2     = IW'(e_sum >>> 1);
        o_prev_o = h_prev_i + e_h2;
    end

endmodule

// File: rtl/idwt53_recon.sv
// Streaming inverse 5/3 DWT: one (L,H) pair in, one (even,odd) pair out.
// Output wraps to DW bits unless IDWT53_SAT_EN is defined.
module idwt53_recon
    import idwt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    idwt53_recon_if.slave bus
);

    state_t               state_q;
    logic signed [IW-1:0] h_q;
    logic signed [IW-1:0] e_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [DW-1:0]        x_even_q;
    logic [DW-1:0]        x_odd_q;

    logic                 out_free;
    logic                 in_fire;
    logic signed [IW-1:0] h_cur;
    logic signed [IW-1:0] h_prev;
    logic signed [IW-1:0] l_cur;
    logic signed [IW-1:0] e_d;
    logic signed [IW-1:0] o_d;

    assign out_free = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q != FLUSH) && out_free;
    assign in_fire = bus.in_valid && bus.in_ready;

    assign h_cur = sext_h(bus.H_in);
    assign l_cur = zext_l(bus.L_in);
    // First pair of a frame mirrors H[-1] = H[0]
    assign h_prev = (state_q == IDLE) ? h_cur : h_q;

    idwt53_lift u_lift (
        .h_prev_i (h_prev),
        .h_cur_i  (h_cur),
        .l_cur_i  (l_cur),
        .e_prev_i (e_q),
        .e_cur_o  (e_d),
        .o_prev_o (o_d)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.x_even    = x_even_q;
    assign bus.x_odd     = x_odd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            h_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            x_even_q    <= '0;
            x_odd_q     <= '0;
        end else begin
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            unique case (1'b1)
                (state_q == IDLE): begin
                    if (in_fire) begin
                        h_q     <= h_cur;
                        e_q     <= e_d;
                        state_q <= bus.in_last ? FLUSH : RUN;
                    end
                end
                (state_q == RUN): begin
                    if (in_fire) begin
                        x_even_q    <= to_out(e_q);
                        x_odd_q     <= to_out(o_d);
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        h_q         <= h_cur;
                        e_q         <= e_d;
                        if (bus.in_last)
                            state_q <= FLUSH;
                    end
                end
                (state_q == FLUSH): begin
                    // Right edge mirrors e[N] = e[N-1]
                    if (out_free) begin
                        x_even_q    <= to_out(e_q);
                        x_odd_q     <= to_out(e_q + h_q);
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idwt53_recon.sv
// Scoreboard bench for idwt53_recon with directed hand-computed vectors.
module tb_idwt53_recon;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idwt53_recon_if bus();

    idwt53_recon dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int e;
        int o;
        bit last;
        int cyc;
    } exp_t;

    exp_t q[$];

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_pair(int e, int o, bit last, int c);
        exp_t x;
        x.e = e;
        x.o = o;
        x.last = last;
        x.cyc = c;
        q.push_back(x);
    endtask

    task automatic send(int l, int h, bit last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.L_in = l[7:0];
        bus.H_in = h[7:0];
        bus.in_last = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: compare every transferred pair; check holding during stalls
    logic [7:0] pe, po;
    logic       pl;
    bit         stalled = 1'b0;

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", int'(bus.in_ready), 0);
                if (stalled) begin
                    check("hold_even", int'(bus.x_even), int'(pe));
                    check("hold_odd", int'(bus.x_odd), int'(po));
                    check("hold_last", int'(bus.out_last), int'(pl));
                end
                stalled = 1'b1;
                pe = bus.x_even;
                po = bus.x_odd;
                pl = bus.out_last;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() != 0) begin
                    x = q.pop_front();
                end else begin
                    x.e = -1;
                    x.o = -1;
                    x.last = 1'b0;
                    x.cyc = -1;
                end
                check("x_even", int'(bus.x_even), x.e);
                check("x_odd", int'(bus.x_odd), x.o);
                check("out_last", int'(bus.out_last), int'(x.last));
                if (x.cyc >= 0)
                    check("latency_cycle", cyc, x.cyc);
            end
        end
    end

    initial begin
        int c0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.L_in = '0;
        bus.H_in = '0;
        bus.out_ready = 1'b1;

        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_x_even", int'(bus.x_even), 0);
        check("rst_x_odd", int'(bus.x_odd), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(bus.in_ready), 1);

        // Constant frame with exact output timing
        c0 = cyc;
        for (int n = 0; n < 7; n++)
            expect_pair(100, 100, 1'b0, c0 + n + 2);
        expect_pair(100, 100, 1'b1, c0 + 9);
        for (int k = 0; k < 8; k++)
            send(100, 0, k == 7);
        idle();
        drain();

        // Two-pair frame
        expect_pair(98, 102, 1'b0, -1);
        expect_pair(98, 102, 1'b1, -1);
        send(100, 4, 1'b0);
        send(100, 4, 1'b1);
        idle();
        drain();

        // Single-pair frame, negative H
        expect_pair(54, 46, 1'b1, -1);
        send(50, -8, 1'b1);
        idle();
        drain();
        check("back_to_idle_in_ready", int'(bus.in_ready), 1);

        // Single pair exceeding the output range
`ifdef IDWT53_SAT_EN
        expect_pair(255, 191, 1'b1, -1);
`else
        expect_pair(63, 191, 1'b1, -1);
`endif
        send(255, -128, 1'b1);
        idle();
        drain();

        // Varied frame under backpressure
        expect_pair(10, 14, 1'b0, -1);
        expect_pair(19, 28, 1'b0, -1);
        expect_pair(30, 30, 1'b0, -1);
        expect_pair(39, 51, 1'b0, -1);
        expect_pair(48, 53, 1'b0, -1);
        expect_pair(59, 61, 1'b1, -1);
        fork
            begin
                send(10, 0, 1'b0);
                send(20, 4, 1'b0);
                send(30, -4, 1'b0);
                send(40, 8, 1'b0);
                send(50, 0, 1'b0);
                send(60, 2, 1'b1);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset during the third pair of a frame
        expect_pair(98, 102, 1'b0, -1);
        send(100, 4, 1'b0);
        send(100, 4, 1'b0);
        bus.L_in = 8'd100;
        bus.H_in = 8'd4;
        #2 rst_n = 1'b0;
        #1;
        check("midframe_rst_out_valid", int'(bus.out_valid), 0);
        check("midframe_rst_queue", q.size(), 0);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_pair(98, 102, 1'b0, -1);
        expect_pair(98, 102, 1'b1, -1);
        send(100, 4, 1'b0);
        send(100, 4, 1'b1);
        idle();
        drain();
        repeat (3) @(negedge clk);
        check("final_out_valid", int'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
